shifter_arbiter: RTL and testbench
==================================

# shifter_arbiter

Shares one 32-bit shift/rotate datapath (LSL/LSR/ASR/ROR, 5-bit amount) between two requesters: port 0 is the core datapath, port 1 is a secondary client such as a multi-cycle multiply/divide sequencer. It grants requests round-robin, computes the shift and shifter carry-out in the grant cycle, and holds the result in a one-entry output register until the consumer accepts it. The block sits beside the ALU operand-2 path.

## Interface
- No parameters; datapath width is fixed at 32, shift amount at 5 bits.
- CLK  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Valid0, Valid1  in  1  request valid, port 0 / port 1.
- Ready0, Ready1  out  1  request accepted this cycle (Valid&Ready = transfer).
- ShIn0, ShIn1  in  32  operand.
- Sh0, Sh1  in  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- Shamt0, Shamt1  in  5  shift amount.
- CarryIn0, CarryIn1  in  1  current C flag of requester.
- OutValid  out  1  result register holds valid data.
- OutReady  in  1  consumer accepts result (OutValid&OutReady = transfer).
- OutTag  out  1  requester index of held result.
- ShOut  out  32  shift result.
- CarryOut  out  1  shifter carry-out.

## Operation
- State: output register (OutValid, OutTag, ShOut, CarryOut) and LastGrant (1 bit).
- FSM is two states, EMPTY (OutValid=0) and FULL (OutValid=1).
- Space = ~OutValid | OutReady. A request is grantable only when Space=1.
- Arbitration when Space=1:
  - Only one Valid set: that port wins.
  - Both set: the port != LastGrant wins.
  - Exactly one Ready goes high, for the winner. Ready is never high for a port whose Valid is low.
- On a transfer, load ShOut, CarryOut and OutTag from the winner's inputs. Set OutValid=1 and LastGrant=winner.
- If OutReady=1 with no new transfer, OutValid goes 0 (FULL->EMPTY).
- If OutReady=1 with a simultaneous transfer, the register is overwritten and stays FULL. The old result counts as consumed.
- Shift rules for n=Shamt:
  - n=0, all types: ShOut=ShIn, CarryOut=CarryIn.
  - LSL: ShOut=ShIn<<n, zero fill; CarryOut=ShIn[32-n].
  - LSR: ShOut=ShIn>>n, zero fill; CarryOut=ShIn[n-1].
  - ASR: ShOut=ShIn>>n, ShIn[31] fill; CarryOut=ShIn[n-1].
  - ROR: ShOut=rotate right by n; CarryOut=ShOut[31].
- Rotation is mod 32 with no wrap beyond 31; amounts 32+ cannot be expressed.
- Ready0/Ready1 are combinational from Valid*, OutValid, OutReady and LastGrant. There is no combinational path from ShIn/Sh/Shamt to any output.

## Timing
- Reset values: OutValid=0, OutTag=0, ShOut=0, CarryOut=0, LastGrant=1, so port 0 wins the first contention.
- Ready0=Ready1=0 in any cycle where Reset=1.
- Latency: a transfer on edge k gives a valid result from edge k to the consumer transfer. That is 1 cycle, request to OutValid.
- Throughput: 1 result/cycle while OutReady=1.
- Backpressure: while OutValid=1 and OutReady=0, both Ready outputs are 0 and all output signals hold stable.
- A requester must hold Valid and its operands stable until it sees Ready. Dropping Valid before Ready is allowed and is a withdrawn request.
- Reset mid-operation: a held result is discarded and OutValid=0 on the next cycle. Pending requests are not accepted during Reset.
- Fairness: with both ports continuously valid and OutReady=1, grants alternate every cycle. Neither port waits more than 1 grant.

## Test plan
- LSL: port0 ShIn=0x80000001, Sh=00, Shamt=1, CarryIn=0 -> next cycle OutValid=1, ShOut=0x00000002, CarryOut=1, OutTag=0.
- ASR/LSR: port1 ShIn=0x80000000, ASR 4 -> ShOut=0xF8000000, CarryOut=0. Then LSR 4 -> 0x08000000. Then Shamt=0 with CarryIn=1 -> ShOut=0x80000000, CarryOut=1.
- ROR: ShIn=0x12345678, Sh=11, Shamt=8 -> ShOut=0x78123456, CarryOut=0. Shamt=31 on 0x00000001 -> 0x00000002, CarryOut=0.
- Contention after reset: both Valid held 6 cycles with distinct operands, OutReady=1 -> OutTag sequence 0,1,0,1,0,1, each with correct ShOut.
- Backpressure: OutValid=1, OutReady=0 for 3 cycles with both Valid high -> Ready0=Ready1=0, ShOut/OutTag unchanged. OutReady=1 -> same-cycle grant, new result the following cycle.
- Reset mid-operation: OutValid=1 holding 0xDEADBEEF, assert Reset 1 cycle -> OutValid=0, ShOut=0, LastGrant=1. The next contention grants port 0.

Source files
------------

// File: rtl/shifter_arbiter_if.sv
// shifter_arbiter_if
//   Groups the two request ports and the result port of the shared shifter.
//   Handshake: a port transfers on a rising edge when its Valid and Ready are
//   both high; the result transfers when OutValid and OutReady are both high.
//   A requester keeps Valid and operands stable until it sees Ready, but may
//   drop Valid earlier to withdraw.
//   slave  : the arbiter side (takes requests, produces the result).
//   master : requesters plus consumer (drive requests, accept the result).
interface shifter_arbiter_if;
  logic        Valid0;
  logic        Valid1;
  logic        Ready0;
  logic        Ready1;
  logic [31:0] ShIn0;
  logic [31:0] ShIn1;
  logic [1:0]  Sh0;
  logic [1:0]  Sh1;
  logic [4:0]  Shamt0;
  logic [4:0]  Shamt1;
  logic        CarryIn0;
  logic        CarryIn1;
  logic        OutValid;
  logic        OutReady;
  logic        OutTag;
  logic [31:0] ShOut;
  logic        CarryOut;

  modport slave (
    input  Valid0, Valid1, ShIn0, ShIn1, Sh0, Sh1, Shamt0, Shamt1,
           CarryIn0, CarryIn1, OutReady,
    output Ready0, Ready1, OutValid, OutTag, ShOut, CarryOut
  );

  modport master (
    output Valid0, Valid1, ShIn0, ShIn1, Sh0, Sh1, Shamt0, Shamt1,
           CarryIn0, CarryIn1, OutReady,
    input  Ready0, Ready1, OutValid, OutTag, ShOut, CarryOut
  );
endinterface

// File: rtl/shifter_arbiter.sv
// shifter_arbiter
//   One 32-bit LSL/LSR/ASR/ROR datapath shared round-robin between port 0
//   (core datapath) and port 1 (secondary sequencer). The shift is computed in
//   the grant cycle and held in a one-entry output register until consumed.
// Ports:
//   CLK      - clock, rising edge
//   Reset    - synchronous active-high reset
//   bus      - shifter_arbiter_if.slave: requests, Ready0/1, result register
//   DbgState - current FSM state (0 = EMPTY, 1 = FULL)
module shifter_arbiter (
  input  logic                  CLK,
  input  logic                  Reset,
  shifter_arbiter_if.slave      bus,
  output logic                  DbgState
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} stateT;

  stateT       state;
  stateT       nextState;
  logic        lastGrant;
  logic        outTagQ;
  logic [31:0] shOutQ;
  logic        carryOutQ;

  logic        space;
  logic        grant0;
  logic        grant1;
  logic        xfer;
  logic [31:0] selIn;
  logic [1:0]  selSh;
  logic [4:0]  selShamt;
  logic        selCarry;
  logic [31:0] shRes;
  logic        shCarry;

  // Shift/rotate with ARM-style carry-out; amount 0 passes operand and carry.
  function automatic logic [32:0] doShift(input logic [31:0] din,
                                          input logic [1:0]  sh,
                                          input logic [4:0]  n,
                                          input logic        cin);
    logic [31:0] res;
    logic        c;
    logic [5:0]  lslIdx;
    logic [4:0]  rIdx;
    lslIdx = 6'd32 - {1'b0, n};
    rIdx   = n - 5'd1;
    res    = din;
    c      = cin;
    if (n != 5'd0) begin
      case (sh)
        2'b00: begin
          res = din << n;
          c   = din[lslIdx[4:0]];
        end
        2'b01: begin
          res = din >> n;
          c   = din[rIdx];
        end
        2'b10: begin
          res = $unsigned($signed(din) >>> n);
          c   = din[rIdx];
        end
        default: begin
          res = (din >> n) | (din << lslIdx);
          c   = res[31];
        end
      endcase
    end
    return {c, res};
  endfunction

  // Room for a new result if empty or the held one leaves this cycle.
  always_comb begin
    space  = (state == EMPTY) | bus.OutReady;
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!Reset && space) begin
      // On contention the port that did not win last time goes first.
      grant0 = bus.Valid0 & (~bus.Valid1 | lastGrant);
      grant1 = bus.Valid1 & (~bus.Valid0 | ~lastGrant);
    end
    xfer = grant0 | grant1;
  end

  // Operand mux feeds the shifter only; nothing from it reaches a port
  // combinationally.
  always_comb begin
    selIn    = grant1 ? bus.ShIn1    : bus.ShIn0;
    selSh    = grant1 ? bus.Sh1      : bus.Sh0;
    selShamt = grant1 ? bus.Shamt1   : bus.Shamt0;
    selCarry = grant1 ? bus.CarryIn1 : bus.CarryIn0;
    {shCarry, shRes} = doShift(selIn, selSh, selShamt, selCarry);
  end

  always_comb begin
    nextState = state;
    if (xfer)
      nextState = FULL;
    else if (bus.OutReady)
      nextState = EMPTY;
  end

  always_ff @(posedge CLK) begin
    if (Reset)
      state <= EMPTY;
    else
      state <= nextState;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      lastGrant <= 1'b1;
      outTagQ   <= 1'b0;
      shOutQ    <= 32'd0;
      carryOutQ <= 1'b0;
    end else if (xfer) begin
      lastGrant <= grant1;
      outTagQ   <= grant1;
      shOutQ    <= shRes;
      carryOutQ <= shCarry;
    end
  end

  assign bus.Ready0   = grant0;
  assign bus.Ready1   = grant1;
  assign bus.OutValid = (state == FULL);
  assign bus.OutTag   = outTagQ;
  assign bus.ShOut    = shOutQ;
  assign bus.CarryOut = carryOutQ;
  assign DbgState     = state;

endmodule

// File: tb/tb_shifter_arbiter.sv
// tb_shifter_arbiter
//   Directed bench for shifter_arbiter: a table of single-request shift
//   vectors, followed by hand-written contention, backpressure and
//   mid-operation reset sequences.
module tb_shifter_arbiter;

  logic CLK;
  logic Reset;
  logic DbgState;

  shifter_arbiter_if bus ();

  shifter_arbiter dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .bus      (bus.slave),
    .DbgState (DbgState)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int nCompared = 0;
  int nMismatch = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic [1:0]  sh;
    logic [4:0]  shamt;
    logic [31:0] shIn;
    logic        cin;
    logic [31:0] expOut;
    logic        expCarry;
  } vecT;

  vecT vecs[$];

  task automatic idleInputs();
    bus.Valid0   = 1'b0;
    bus.Valid1   = 1'b0;
    bus.ShIn0    = 32'd0;
    bus.ShIn1    = 32'd0;
    bus.Sh0      = 2'b00;
    bus.Sh1      = 2'b00;
    bus.Shamt0   = 5'd0;
    bus.Shamt1   = 5'd0;
    bus.CarryIn0 = 1'b0;
    bus.CarryIn1 = 1'b0;
  endtask

  task automatic drivePort(input logic port, input logic [1:0] sh,
                           input logic [4:0] shamt, input logic [31:0] shIn,
                           input logic cin);
    if (port == 1'b0) begin
      bus.Valid0 = 1'b1; bus.Sh0 = sh; bus.Shamt0 = shamt;
      bus.ShIn0 = shIn;  bus.CarryIn0 = cin;
    end else begin
      bus.Valid1 = 1'b1; bus.Sh1 = sh; bus.Shamt1 = shamt;
      bus.ShIn1 = shIn;  bus.CarryIn1 = cin;
    end
  endtask

  initial begin
    idleInputs();
    bus.OutReady = 1'b0;
    Reset = 1'b1;

    // Reset state; Ready must stay low during reset even with requests.
    @(negedge CLK);
    drivePort(1'b0, 2'b00, 5'd1, 32'h1, 1'b0);
    drivePort(1'b1, 2'b00, 5'd1, 32'h1, 1'b0);
    #1;
    check("reset_ready0", {31'd0, bus.Ready0}, 32'd0);
    check("reset_ready1", {31'd0, bus.Ready1}, 32'd0);
    @(negedge CLK);
    check("reset_outvalid", {31'd0, bus.OutValid}, 32'd0);
    check("reset_shout", bus.ShOut, 32'd0);
    check("reset_carry", {31'd0, bus.CarryOut}, 32'd0);
    check("reset_tag", {31'd0, bus.OutTag}, 32'd0);
    idleInputs();
    Reset = 1'b0;
    bus.OutReady = 1'b1;

    // Vector table: port, type, amount, operand, carry-in, result, carry-out
    vecs.push_back('{1'b0, 2'b00, 5'd1,  32'h80000001, 1'b0, 32'h00000002, 1'b1});
    vecs.push_back('{1'b1, 2'b10, 5'd4,  32'h80000000, 1'b0, 32'hF8000000, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 5'd4,  32'h80000000, 1'b0, 32'h08000000, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 5'd0,  32'h80000000, 1'b1, 32'h80000000, 1'b1});
    vecs.push_back('{1'b0, 2'b11, 5'd8,  32'h12345678, 1'b0, 32'h78123456, 1'b0});
    vecs.push_back('{1'b1, 2'b11, 5'd31, 32'h00000001, 1'b0, 32'h00000002, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 5'd29, 32'h0000000F, 1'b0, 32'hE0000000, 1'b1});
    vecs.push_back('{1'b0, 2'b10, 5'd31, 32'h7FFFFFFF, 1'b0, 32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 2'b10, 5'd31, 32'hFFFFFFF0, 1'b0, 32'hFFFFFFFF, 1'b1});
    vecs.push_back('{1'b0, 2'b01, 5'd1,  32'h00000001, 1'b0, 32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 2'b00, 5'd31, 32'h00000001, 1'b1, 32'h80000000, 1'b0});
    vecs.push_back('{1'b0, 2'b11, 5'd1,  32'h00000001, 1'b0, 32'h80000000, 1'b1});
    vecs.push_back('{1'b0, 2'b00, 5'd0,  32'h000000A5, 1'b0, 32'h000000A5, 1'b0});

    foreach (vecs[i]) begin
      @(negedge CLK);
      idleInputs();
      drivePort(vecs[i].port, vecs[i].sh, vecs[i].shamt, vecs[i].shIn,
                vecs[i].cin);
      #1;
      check($sformatf("v%0d_ready", i),
            {30'd0, bus.Ready1, bus.Ready0},
            (vecs[i].port ? 32'd2 : 32'd1));
      @(posedge CLK);
      #1;
      check($sformatf("v%0d_valid", i), {31'd0, bus.OutValid}, 32'd1);
      check($sformatf("v%0d_shout", i), bus.ShOut, vecs[i].expOut);
      check($sformatf("v%0d_carry", i), {31'd0, bus.CarryOut},
            {31'd0, vecs[i].expCarry});
      check($sformatf("v%0d_tag", i), {31'd0, bus.OutTag},
            {31'd0, vecs[i].port});
    end

    // Drain with no new request: FULL -> EMPTY.
    @(negedge CLK);
    idleInputs();
    @(posedge CLK);
    #1;
    check("drain_outvalid", {31'd0, bus.OutValid}, 32'd0);

    // Contention right after a reset: port 0 first, then strict alternation.
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    drivePort(1'b0, 2'b00, 5'd4, 32'h00000011, 1'b0);
    drivePort(1'b1, 2'b01, 5'd8, 32'h00000100, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge CLK);
      #1;
      check($sformatf("cont%0d_ready", i), {30'd0, bus.Ready1, bus.Ready0},
            (i % 2 == 0) ? 32'd1 : 32'd2);
      @(posedge CLK);
      #1;
      check($sformatf("cont%0d_tag", i), {31'd0, bus.OutTag},
            (i % 2 == 0) ? 32'd0 : 32'd1);
      check($sformatf("cont%0d_shout", i), bus.ShOut,
            (i % 2 == 0) ? 32'h00000110 : 32'h00000001);
    end

    // Backpressure: result from port 1 held, both ports still requesting.
    @(negedge CLK);
    bus.OutReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp%0d_ready", i), {30'd0, bus.Ready1, bus.Ready0}, 32'd0);
      check($sformatf("bp%0d_valid", i), {31'd0, bus.OutValid}, 32'd1);
      check($sformatf("bp%0d_shout", i), bus.ShOut, 32'h00000001);
      check($sformatf("bp%0d_tag", i), {31'd0, bus.OutTag}, 32'd1);
      @(negedge CLK);
    end
    bus.OutReady = 1'b1;
    #1;
    check("bp_release_ready", {30'd0, bus.Ready1, bus.Ready0}, 32'd1);
    @(posedge CLK);
    #1;
    check("bp_release_tag", {31'd0, bus.OutTag}, 32'd0);
    check("bp_release_shout", bus.ShOut, 32'h00000110);

    // Reset mid-operation with 0xDEADBEEF held.
    @(negedge CLK);
    idleInputs();
    drivePort(1'b1, 2'b00, 5'd0, 32'hDEADBEEF, 1'b0);
    @(posedge CLK);
    #1;
    check("mid_load_shout", bus.ShOut, 32'hDEADBEEF);
    check("mid_load_tag", {31'd0, bus.OutTag}, 32'd1);
    @(negedge CLK);
    bus.OutReady = 1'b0;
    drivePort(1'b0, 2'b00, 5'd1, 32'h00000003, 1'b0);
    drivePort(1'b1, 2'b00, 5'd2, 32'h00000003, 1'b0);
    Reset = 1'b1;
    bus.OutReady = 1'b1;
    #1;
    check("mid_reset_ready", {30'd0, bus.Ready1, bus.Ready0}, 32'd0);
    @(posedge CLK);
    #1;
    check("mid_reset_outvalid", {31'd0, bus.OutValid}, 32'd0);
    check("mid_reset_shout", bus.ShOut, 32'd0);
    check("mid_reset_state", {31'd0, DbgState}, 32'd0);
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    check("post_reset_ready", {30'd0, bus.Ready1, bus.Ready0}, 32'd1);
    @(posedge CLK);
    #1;
    check("post_reset_tag", {31'd0, bus.OutTag}, 32'd0);
    check("post_reset_shout", bus.ShOut, 32'h00000006);

    @(negedge CLK);
    idleInputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
